// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 multiply sequencer.
package fpu_pkg;

  localparam int unsigned FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  // Index of the final multiplier step (24 steps, 0..23).
  localparam logic [4:0]  MUL_LAST_CNT = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/fpu_mul_iter.sv
// 24x24 iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
module fpu_mul_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [47:0] prod
);

  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [47:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  // Load on start, otherwise add-and-shift while busy.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {24'd0, mcand};
      mplier_d = mplier;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == MUL_LAST_CNT) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // done flags the cycle whose edge performs the last step; prod is final after it.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == MUL_LAST_CNT);
  assign prod = acc_q;

endmodule

// File: rtl/fpu_mul_seq.sv
// Single-precision multiply sequencer: special-case screen, iterative multiply,
// normalize and round-to-nearest-even, with valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// MUL   | iterative mantissa multiply running (24 cycles)
// NORM  | normalize, round, detect overflow/underflow
// DONE  | out_valid high, result held until out_ready
module fpu_mul_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_nv,
  output logic        flag_of,
  output logic        flag_uf,
  output logic        flag_nx
);

  mul_state_e         state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [31:0]        result_q, result_d;
  logic [3:0]         flags_q, flags_d;  // {nv, of, uf, nx}

  logic               iter_start, iter_busy, iter_done;
  logic [47:0]        prod;

  fpu_mul_iter u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .mcand  ({1'b1, op_a[22:0]}),
    .mplier ({1'b1, op_b[22:0]}),
    .busy   (iter_busy),
    .done   (iter_done),
    .prod   (prod)
  );

  logic [7:0]         ea, eb;
  logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic [22:0]        mant;
  logic               guard, sticky, rnd_inc;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_pre, exp_rnd;

  // Operand classification, normalization/rounding, and next-state logic.
  always_comb begin
    ea     = op_a[30:23];
    eb     = op_b[30:23];
    a_nan  = (ea == FP32_EXP_MAX) && (op_a[22:0] != 23'd0);
    b_nan  = (eb == FP32_EXP_MAX) && (op_b[22:0] != 23'd0);
    a_snan = a_nan && !op_a[22];
    b_snan = b_nan && !op_b[22];
    a_inf  = (ea == FP32_EXP_MAX) && (op_a[22:0] == 23'd0);
    b_inf  = (eb == FP32_EXP_MAX) && (op_b[22:0] == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);

    if (prod[47]) begin
      mant    = prod[46:24];
      guard   = prod[23];
      sticky  = |prod[22:0];
      exp_pre = exp_q + 10'sd1;
    end else begin
      mant    = prod[45:23];
      guard   = prod[22];
      sticky  = |prod[21:0];
      exp_pre = exp_q;
    end
    rnd_inc  = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {23'd0, rnd_inc};
    // A carry out leaves mant_rnd[22:0] all zero, so only the exponent moves.
    exp_rnd  = exp_pre + $signed({9'd0, mant_rnd[23]});

    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    result_d   = result_q;
    flags_d    = flags_q;
    iter_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && !iter_busy) begin
          sign_d = op_a[31] ^ op_b[31];
          if (a_nan || b_nan) begin
            result_d = FP32_QNAN;
            flags_d  = {a_snan | b_snan, 3'b000};
            state_d  = ST_DONE;
          end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            result_d = FP32_QNAN;
            flags_d  = 4'b1000;
            state_d  = ST_DONE;
          end else if (a_inf || b_inf) begin
            result_d = {op_a[31] ^ op_b[31], FP32_EXP_MAX, 23'd0};
            flags_d  = 4'b0000;
            state_d  = ST_DONE;
          end else if (a_zero || b_zero) begin
            result_d = {op_a[31] ^ op_b[31], 31'd0};
            flags_d  = 4'b0000;
            state_d  = ST_DONE;
          end else begin
            exp_d      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
            iter_start = 1'b1;
            state_d    = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (iter_done) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (exp_rnd >= 10'sd255) begin
          result_d = {sign_q, FP32_EXP_MAX, 23'd0};
          flags_d  = 4'b0101;
        end else if (exp_rnd <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          flags_d  = 4'b0011;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
          flags_d  = {3'b000, guard | sticky};
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !iter_busy;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flag_nv   = flags_q[3];
  assign flag_of   = flags_q[2];
  assign flag_uf   = flags_q[1];
  assign flag_nx   = flags_q[0];

endmodule
